bram_read_streamer: RTL and testbench

Read-side BRAM engine for the bram_accessor path. Kicked by the same start/length pair as the run counter FSM, it issues sequential BRAM reads from a captured base address, absorbs the BRAM read latency, and presents the data as a valid/ready stream with a last marker. A credit-limited output FIFO ensures downstream backpressure never drops a read.

---
 rtl/bram_accessor_pkg.sv | 32 +++
 rtl/bram_read_streamer_if.sv | 34 +++
 rtl/stream_sync_fifo.sv | 66 ++++++
 rtl/bram_read_streamer.sv | 131 +++++++++++++
 tb/tb_bram_read_streamer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_accessor_pkg.sv
// Shared definitions for the bram_accessor read path: FSM state encoding and BRAM read latency.
// BRAM_READER_OUT_REG_EN selects a 2-cycle BRAM read latency (output register in use); default is 1.
package bram_accessor_pkg;

`ifdef BRAM_READER_OUT_REG_EN
   localparam int BRAM_RD_LAT = 2;
`else
   localparam int BRAM_RD_LAT = 1;
`endif

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_ISSUE = ISSUE,
      ST_DRAIN = DRAIN,
      ST_DONE  = DONE
   } state_e;

   function automatic int unsigned count_ones(input logic [BRAM_RD_LAT-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < BRAM_RD_LAT; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/bram_read_streamer_if.sv
// BRAM read port plus valid/ready output stream of the read streamer.
// master = streamer side, slave = BRAM/downstream side.
interface bram_read_streamer_if #(
   parameter int AWIDTH = 12,
   parameter int DWIDTH = 32
);
   logic              bram_ce_o;
   logic [AWIDTH-1:0] bram_addr_o;
   logic [DWIDTH-1:0] bram_q_i;
   logic              m_valid_o;
   logic              m_ready_i;
   logic [DWIDTH-1:0] m_data_o;
   logic              m_last_o;

   modport master (
      output bram_ce_o,
      output bram_addr_o,
      input  bram_q_i,
      output m_valid_o,
      input  m_ready_i,
      output m_data_o,
      output m_last_o
   );

   modport slave (
      input  bram_ce_o,
      input  bram_addr_o,
      output bram_q_i,
      input  m_valid_o,
      output m_ready_i,
      input  m_data_o,
      input  m_last_o
   );
endinterface

// File: rtl/stream_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO; output is taken straight from the storage registers.
// No write-through: a word written this cycle becomes visible the next cycle.
module stream_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   wr_en_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   rd_en_i,
   output logic [WIDTH-1:0]       rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             do_wr;
   logic             do_rd;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_wr     = wr_en_i && !full_o;
   assign do_rd     = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + 1'b1;
      end else if (!do_wr && do_rd) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/bram_read_streamer.sv
// Sequential BRAM reader: issues credit-limited reads and streams the data out with a last marker.
// BRAM_READER_OUT_REG_EN (via bram_accessor_pkg) lengthens the read delay line from 1 to 2 stages.
module bram_read_streamer
   import bram_accessor_pkg::*;
#(
   parameter int CNT_BIT    = 31,
   parameter int AWIDTH     = 12,
   parameter int DWIDTH     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_i,
   input  logic [CNT_BIT-1:0] len_i,
   input  logic [AWIDTH-1:0]  base_addr_i,
   bram_read_streamer_if.master bus,
   output logic [CNT_BIT-1:0] cnt_o,
   output logic               busy_o,
   output logic               done_o
);
   state_e             state_q, state_d;
   logic [CNT_BIT-1:0] len_q, len_d;
   logic [CNT_BIT-1:0] cnt_q, cnt_d;
   logic [AWIDTH-1:0]  base_q, base_d;

   logic [BRAM_RD_LAT-1:0] vld_q;
   logic [BRAM_RD_LAT-1:0] last_q;

   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [DWIDTH:0]             fifo_rd_data;

   logic credit_ok;
   logic issue;
   logic issue_last;
   logic beat;
   logic out_valid;

   // Credit counts words already queued plus reads still inside the BRAM pipe.
   assign credit_ok  = (32'(fifo_count) + count_ones(vld_q)) < 32'(FIFO_DEPTH);
   assign issue      = (state_q == ST_ISSUE) && credit_ok;
   assign issue_last = issue && (cnt_q == len_q - CNT_BIT'(1));
   assign out_valid  = !fifo_empty;
   assign beat       = out_valid && bus.m_ready_i;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               len_d   = len_i;
               base_d  = base_addr_i;
               cnt_d   = '0;
               state_d = (len_i != '0) ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            if (issue) begin
               cnt_d = cnt_q + CNT_BIT'(1);
               if (issue_last) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (beat && fifo_rd_data[DWIDTH]) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
      end
   end

   // Delay line tracks each read through the BRAM so its data is captured on arrival.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q  <= '0;
         last_q <= '0;
      end else begin
         vld_q[0]  <= issue;
         last_q[0] <= issue_last;
         for (int k = 1; k < BRAM_RD_LAT; k++) begin
            vld_q[k]  <= vld_q[k-1];
            last_q[k] <= last_q[k-1];
         end
      end
   end

   stream_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DWIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (vld_q[BRAM_RD_LAT-1] && !fifo_full),
      .wr_data_i ({last_q[BRAM_RD_LAT-1], bus.bram_q_i}),
      .rd_en_i   (bus.m_ready_i),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign bus.bram_ce_o   = issue;
   assign bus.bram_addr_o = issue ? (base_q + AWIDTH'(cnt_q)) : '0;
   assign bus.m_valid_o   = out_valid;
   assign bus.m_data_o    = out_valid ? fifo_rd_data[DWIDTH-1:0] : '0;
   assign bus.m_last_o    = out_valid && fifo_rd_data[DWIDTH];

   assign cnt_o  = cnt_q;
   assign busy_o = (state_q != ST_IDLE);
   assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_read_streamer.sv
// Scoreboard bench for bram_read_streamer: directed transfers, stall, wrap, len=0, ignored start, reset abort.
module tb_bram_read_streamer;

`ifdef BRAM_READER_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start_i = 1'b0;
   logic [30:0] len_i = '0;
   logic [11:0] base_addr_i = '0;
   logic [30:0] cnt_o;
   logic        busy_o;
   logic        done_o;

   bram_read_streamer_if #(.AWIDTH(12), .DWIDTH(32)) bus ();

   bram_read_streamer #(
      .CNT_BIT    (31),
      .AWIDTH     (12),
      .DWIDTH     (32),
      .FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (start_i),
      .len_i       (len_i),
      .base_addr_i (base_addr_i),
      .bus         (bus.master),
      .cnt_o       (cnt_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int ce_cnt = 0;
   int ce_first = -1;
   int done_cnt = 0;
   int done_rel = -1;
   int beat_cyc[$];
   logic [11:0] addr_q[$];
   beat_t       exp_q[$];

   function automatic logic [31:0] data_of(input logic [11:0] a);
      return 32'hC0DE_0000 | {20'h0, a};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // BRAM model: synchronous read, optional output register
   logic [31:0] q1 = '0;
   logic [31:0] q2 = '0;
   always @(posedge clk) begin
      if (bus.bram_ce_o) q1 <= data_of(bus.bram_addr_o);
      q2 <= q1;
   end
`ifdef BRAM_READER_OUT_REG_EN
   assign bus.bram_q_i = q2;
`else
   assign bus.bram_q_i = q1;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops scoreboard queues whenever the DUT presents a read or a beat
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;
   always @(negedge clk) begin
      int rel;
      rel = cyc - t0 + 1;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.bram_ce_o) begin
            ce_cnt++;
            if (ce_cnt == 1) ce_first = rel;
            if (addr_q.size() == 0) begin
               check("unexpected_read", 64'(bus.bram_addr_o), 64'hFFFF_FFFF);
            end else begin
               check("bram_addr", 64'(bus.bram_addr_o), 64'(addr_q.pop_front()));
            end
         end
         if (prev_stall && bus.m_valid_o) begin
            check("stall_data_hold", 64'(bus.m_data_o), 64'(prev_data));
            check("stall_last_hold", 64'(bus.m_last_o), 64'(prev_last));
         end
         if (bus.m_valid_o && bus.m_ready_i) begin
            beat_t e;
            beat_cyc.push_back(rel);
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(bus.m_data_o), 64'hFFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", 64'(bus.m_data_o), 64'(e.d));
               check("beat_last", 64'(bus.m_last_o), 64'(e.l));
            end
         end
         prev_stall = bus.m_valid_o && !bus.m_ready_i;
         prev_data  = bus.m_data_o;
         prev_last  = bus.m_last_o;
         if (done_o) begin
            done_cnt++;
            done_rel = rel;
         end
      end
   end

   task automatic clear_stats();
      ce_cnt = 0;
      ce_first = -1;
      done_cnt = 0;
      done_rel = -1;
      beat_cyc.delete();
   endtask

   // Drives start for one cycle; edge 0 is the edge that samples it.
   task automatic kick(input logic [30:0] len, input logic [11:0] base);
      @(posedge clk);
      #1;
      clear_stats();
      start_i = 1'b1;
      len_i = len;
      base_addr_i = base;
      for (int i = 0; i < int'(len); i++) begin
         logic [11:0] a;
         a = base + 12'(i);
         addr_q.push_back(a);
         exp_q.push_back('{d: data_of(a), l: (i == int'(len) - 1)});
      end
      @(posedge clk);
      #1;
      t0 = cyc;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_ce"}, 64'(bus.bram_ce_o), 64'd0);
      check({name, "_addr"}, 64'(bus.bram_addr_o), 64'd0);
      check({name, "_valid"}, 64'(bus.m_valid_o), 64'd0);
      check({name, "_data"}, 64'(bus.m_data_o), 64'd0);
      check({name, "_last"}, 64'(bus.m_last_o), 64'd0);
      check({name, "_cnt"}, 64'(cnt_o), 64'd0);
      check({name, "_busy"}, 64'(busy_o), 64'd0);
      check({name, "_done"}, 64'(done_o), 64'd0);
   endtask

   initial begin
      bus.m_ready_i = 1'b0;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      reset_n = 1'b1;

      // Basic transfer: base 0x010, len 4, always ready
      bus.m_ready_i = 1'b1;
      kick(31'd4, 12'h010);
      wait_done("t1", 40);
      check("t1_first_ce_cycle", 64'(ce_first), 64'd1);
      check("t1_ce_count", 64'(ce_cnt), 64'd4);
      check("t1_beat_count", 64'(beat_cyc.size()), 64'd4);
      if (beat_cyc.size() == 4) begin
         check("t1_first_beat_cycle", 64'(beat_cyc[0]), 64'(2 + LAT));
         check("t1_last_beat_cycle", 64'(beat_cyc[3]), 64'(5 + LAT));
      end
      check("t1_done_cycle", 64'(done_rel), 64'(6 + LAT));
      check("t1_idle_after_done", 64'(busy_o), 64'd0);
      check("t1_cnt_final", 64'(cnt_o), 64'd4);

      // Backpressure: len 8 with ready low, credit must cap reads at FIFO depth
      bus.m_ready_i = 1'b0;
      kick(31'd8, 12'h100);
      repeat (20) @(posedge clk);
      #1;
      check("t2_stalled_reads", 64'(ce_cnt), 64'd4);
      check("t2_ce_held_low", 64'(bus.bram_ce_o), 64'd0);
      check("t2_cnt_stalled", 64'(cnt_o), 64'd4);
      check("t2_valid_stalled", 64'(bus.m_valid_o), 64'd1);
      check("t2_busy_stalled", 64'(busy_o), 64'd1);
      bus.m_ready_i = 1'b1;
      wait_done("t2", 80);
      check("t2_total_reads", 64'(ce_cnt), 64'd8);
      check("t2_beats", 64'(beat_cyc.size()), 64'd8);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Address wrap at 2^AWIDTH
      kick(31'd4, 12'hFFE);
      wait_done("t3", 40);
      check("t3_reads", 64'(ce_cnt), 64'd4);
      check("t3_addr_queue_empty", 64'(addr_q.size()), 64'd0);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Zero-length transfer: no reads, straight to DONE
      kick(31'd0, 12'h123);
      check("t4_busy_c1", 64'(busy_o), 64'd1);
      check("t4_done_c1", 64'(done_o), 64'd1);
      @(posedge clk);
      #1;
      check("t4_busy_c2", 64'(busy_o), 64'd0);
      check("t4_done_c2", 64'(done_o), 64'd0);
      check("t4_reads", 64'(ce_cnt), 64'd0);
      check("t4_done_cycle", 64'(done_rel), 64'd1);

      // start_i during DRAIN must be ignored
      bus.m_ready_i = 1'b0;
      kick(31'd3, 12'h200);
      repeat (8) @(posedge clk);
      #1;
      check("t5_cnt_before", 64'(cnt_o), 64'd3);
      start_i = 1'b1;
      len_i = 31'd5;
      base_addr_i = 12'h300;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("t5_cnt_after_start", 64'(cnt_o), 64'd3);
      check("t5_busy_after_start", 64'(busy_o), 64'd1);
      bus.m_ready_i = 1'b1;
      wait_done("t5", 40);
      check("t5_reads", 64'(ce_cnt), 64'd3);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("t5_no_restart_busy", 64'(busy_o), 64'd0);
      check("t5_no_restart_reads", 64'(ce_cnt), 64'd3);

      // Reset mid-ISSUE aborts; next transfer behaves as from power-on
      kick(31'd6, 12'h080);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_outputs_zero("t6_abort");
      addr_q.delete();
      exp_q.delete();
      clear_stats();
      repeat (2) @(posedge clk);
      #1;
      check("t6_no_done_in_reset", 64'(done_cnt), 64'd0);
      reset_n = 1'b1;
      kick(31'd2, 12'h040);
      wait_done("t6", 40);
      check("t6_first_ce_cycle", 64'(ce_first), 64'd1);
      check("t6_reads", 64'(ce_cnt), 64'd2);
      check("t6_beat_count", 64'(beat_cyc.size()), 64'd2);
      if (beat_cyc.size() == 2) begin
         check("t6_first_beat_cycle", 64'(beat_cyc[0]), 64'(2 + LAT));
      end
      check("t6_done_cycle", 64'(done_rel), 64'(4 + LAT));
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
